// File: rtl/tblink_rpc_arb_pkg.sv
// rtl/tblink_rpc_arb_pkg.sv - shared types, defaults and ID width helper for the RPC invoke arbiter
package tblink_rpc_arb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } req_state_e;

  localparam int TIMEOUT_DEFAULT = 1024;

  // Never return 0 so a degenerate requester count still yields a legal vector width.
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tblink_rpc_invoke_arbiter_if.sv
// rtl/tblink_rpc_invoke_arbiter_if.sv - requester and endpoint channels of the RPC invoke arbiter
interface tblink_rpc_invoke_arbiter_if
  import tblink_rpc_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int METHOD_W = 8,
  parameter int DATA_W   = 64
);
  localparam int ID_W = calc_id_w(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          req_blocking;
  logic [N_REQ*METHOD_W-1:0] req_method;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [N_REQ-1:0]          busy;
  logic                      ep_valid;
  logic                      ep_ready;
  logic [ID_W-1:0]           ep_id;
  logic                      ep_blocking;
  logic [METHOD_W-1:0]       ep_method;
  logic [DATA_W-1:0]         ep_data;
  logic                      ep_rsp_valid;
  logic [ID_W-1:0]           ep_rsp_id;
  logic [DATA_W-1:0]         ep_rsp_data;
  logic                      unsolicited;

  modport master (
    output req_valid, req_blocking, req_method, req_data,
    output ep_ready, ep_rsp_valid, ep_rsp_id, ep_rsp_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
    input  ep_valid, ep_id, ep_blocking, ep_method, ep_data, unsolicited
  );

  modport slave (
    input  req_valid, req_blocking, req_method, req_data,
    input  ep_ready, ep_rsp_valid, ep_rsp_id, ep_rsp_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy,
    output ep_valid, ep_id, ep_blocking, ep_method, ep_data, unsolicited
  );

endinterface

// File: rtl/tblink_rpc_rr_arbiter.sv
// rtl/tblink_rpc_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module tblink_rpc_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  winner_o,
  output logic             valid_o
);

  always_comb begin
    int idx;
    idx      = 0;
    grant_o  = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!valid_o && elig_i[idx]) begin
        valid_o     = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/tblink_rpc_invoke_arbiter.sv
// rtl/tblink_rpc_invoke_arbiter.sv - shares one RPC endpoint among N_REQ requesters, routes responses back
// Optional response watchdog enabled by defining TBLINK_RPC_ARB_TIMEOUT_EN.
module tblink_rpc_invoke_arbiter
  import tblink_rpc_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int METHOD_W = 8,
  parameter int DATA_W   = 64,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input logic                   clock,
  input logic                   reset_n,
  tblink_rpc_invoke_arbiter_if.slave bus
);
  localparam int ID_W = calc_id_w(N_REQ);

  req_state_e          state_q [N_REQ];
  logic [N_REQ-1:0]    busy, elig, grant;
  logic [ID_W-1:0]     winner, ptr_q, ep_id_q;
  logic                any_elig, load, accept, rsp_id_ok, rsp_hit;
  logic                ep_valid_q, ep_blocking_q, rsp_err_q, unsol_q;
  logic [METHOD_W-1:0] ep_method_q;
  logic [DATA_W-1:0]   ep_data_q, rsp_data_q;
  logic [N_REQ-1:0]    rsp_valid_q;

  always_comb begin
    busy = '0;
    for (int i = 0; i < N_REQ; i++) busy[i] = (state_q[i] == WAIT_RSP);
  end

  assign elig = bus.req_valid & ~busy;

  tblink_rpc_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .elig_i   (elig),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner),
    .valid_o  (any_elig)
  );

  // Gating with reset_n keeps req_ready low while the flops are held in reset.
  assign load          = !ep_valid_q || bus.ep_ready;
  assign accept        = reset_n && any_elig && load;
  assign bus.req_ready = accept ? grant : '0;

  if (N_REQ == (1 << ID_W)) begin : g_id_full
    assign rsp_id_ok = 1'b1;
  end else begin : g_id_part
    assign rsp_id_ok = (bus.ep_rsp_id < ID_W'(N_REQ));
  end
  assign rsp_hit = bus.ep_rsp_valid && rsp_id_ok && busy[bus.ep_rsp_id];

`ifdef TBLINK_RPC_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic             to_any;
  logic [ID_W-1:0]  to_idx;

  // A real response owns the shared result path this cycle; expired requesters wait with counters held.
  always_comb begin
    to_any = 1'b0;
    to_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!to_any && busy[i] && (cnt_q[i] == CNT_W'(TIMEOUT - 1)) &&
          !(rsp_hit && (bus.ep_rsp_id == ID_W'(i)))) begin
        to_any = 1'b1;
        to_idx = ID_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) state_q[i] <= IDLE;
      ptr_q         <= '0;
      ep_valid_q    <= 1'b0;
      ep_id_q       <= '0;
      ep_blocking_q <= 1'b0;
      ep_method_q   <= '0;
      ep_data_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      unsol_q       <= 1'b0;
`ifdef TBLINK_RPC_ARB_TIMEOUT_EN
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      unsol_q     <= 1'b0;

      if (load) ep_valid_q <= accept;
      if (accept) begin
        ep_id_q       <= winner;
        ep_blocking_q <= bus.req_blocking[winner];
        ep_method_q   <= bus.req_method[winner*METHOD_W +: METHOD_W];
        ep_data_q     <= bus.req_data[winner*DATA_W +: DATA_W];
        ptr_q         <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
        if (bus.req_blocking[winner]) state_q[winner] <= WAIT_RSP;
      end

      if (rsp_hit) begin
        rsp_valid_q[bus.ep_rsp_id] <= 1'b1;
        rsp_data_q                 <= bus.ep_rsp_data;
        state_q[bus.ep_rsp_id]     <= IDLE;
      end else if (bus.ep_rsp_valid) begin
        unsol_q <= 1'b1;
      end

`ifdef TBLINK_RPC_ARB_TIMEOUT_EN
      for (int i = 0; i < N_REQ; i++) begin
        if (!busy[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] != CNT_W'(TIMEOUT - 1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (!rsp_hit && to_any) begin
        rsp_valid_q[to_idx] <= 1'b1;
        rsp_err_q           <= 1'b1;
        rsp_data_q          <= '0;
        state_q[to_idx]     <= IDLE;
      end
`endif
    end
  end

  assign bus.busy        = busy;
  assign bus.ep_valid    = ep_valid_q;
  assign bus.ep_id       = ep_id_q;
  assign bus.ep_blocking = ep_blocking_q;
  assign bus.ep_method   = ep_method_q;
  assign bus.ep_data     = ep_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.unsolicited = unsol_q;

endmodule

// File: tb/tb_tblink_rpc_invoke_arbiter.sv
// tb/tb_tblink_rpc_invoke_arbiter.sv - scoreboard bench for the RPC invoke arbiter
// Timeout scenario compiled in when TBLINK_RPC_ARB_TIMEOUT_EN is defined.
module tb_tblink_rpc_invoke_arbiter;

  localparam int N = 4;
  localparam int MW = 8;
  localparam int DW = 64;

  typedef struct {
    logic [1:0]  id;
    logic        blk;
    logic [7:0]  m;
    logic [63:0] d;
  } call_t;

  typedef struct {
    logic [3:0]  vec;
    logic [63:0] d;
    logic        err;
  } rsp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  call_t exp_calls[$];
  rsp_t  exp_rsps[$];
  call_t mc;
  rsp_t  mr;

  tblink_rpc_invoke_arbiter_if #(.N_REQ(N), .METHOD_W(MW), .DATA_W(DW)) bus ();

  tblink_rpc_invoke_arbiter #(.N_REQ(N), .METHOD_W(MW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_call(input int id, input bit blk, input int m, input logic [63:0] d);
    call_t c;
    c.id = 2'(id); c.blk = blk; c.m = 8'(m); c.d = d;
    exp_calls.push_back(c);
  endtask

  task automatic push_rsp(input logic [3:0] vec, input logic [63:0] d, input bit err);
    rsp_t r;
    r.vec = vec; r.d = d; r.err = err;
    exp_rsps.push_back(r);
  endtask

  task automatic set_req(input int i, input bit v, input bit blk, input int m, input logic [63:0] d);
    bus.req_valid[i]          = v;
    bus.req_blocking[i]       = blk;
    bus.req_method[i*MW +: MW] = 8'(m);
    bus.req_data[i*DW +: DW]   = d;
  endtask

  task automatic send_rsp(input int id, input logic [63:0] d);
    bus.ep_rsp_valid = 1'b1;
    bus.ep_rsp_id    = 2'(id);
    bus.ep_rsp_data  = d;
  endtask

  // Endpoint-side scoreboard: every transfer and every response pulse must match the next expectation.
  always @(negedge clk) begin
    if (bus.ep_valid && bus.ep_ready) begin
      n_chk++;
      assert (exp_calls.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_call: observed id %0d with empty queue, required no transfer", bus.ep_id);
      end
      if (exp_calls.size() != 0) begin
        mc = exp_calls.pop_front();
        check("ep_id", 64'(bus.ep_id), 64'(mc.id));
        check("ep_blocking", 64'(bus.ep_blocking), 64'(mc.blk));
        check("ep_method", 64'(bus.ep_method), 64'(mc.m));
        check("ep_data", bus.ep_data, mc.d);
      end
    end
    if (bus.rsp_valid != 0) begin
      n_chk++;
      assert (exp_rsps.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_rsp: observed rsp_valid %0h, required 0", bus.rsp_valid);
      end
      if (exp_rsps.size() != 0) begin
        mr = exp_rsps.pop_front();
        check("rsp_vec", 64'(bus.rsp_valid), 64'(mr.vec));
        check("rsp_data", bus.rsp_data, mr.d);
        check("rsp_err", 64'(bus.rsp_err), 64'(mr.err));
      end
    end
  end

  initial begin
    bus.req_valid = '0; bus.req_blocking = '0; bus.req_method = '0; bus.req_data = '0;
    bus.ep_ready = 1'b0; bus.ep_rsp_valid = 1'b0; bus.ep_rsp_id = '0; bus.ep_rsp_data = '0;
    tick(2);
    bus.req_valid = 4'hF;
    #1;
    check("rst_ep_valid", 64'(bus.ep_valid), 0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("rst_rsp_err", 64'(bus.rsp_err), 0);
    check("rst_unsol", 64'(bus.unsolicited), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_req_ready", 64'(bus.req_ready), 0);
    bus.req_valid = '0;
    tick(1);
    rst_n = 1'b1;
    bus.ep_ready = 1'b1;
    tick(1);

    // Round-robin fairness with continuous non-blocking calls
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 8'h10 + i, 64'h100 + i);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_call(i, 1'b0, 8'h10 + i, 64'h100 + i);
    #1;
    check("rr_first_ready", 64'(bus.req_ready), 64'h1);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("rr_no_busy", 64'(bus.busy), 0);
    end
    bus.req_valid = '0;
    tick(2);
    check("rr_drained", 64'(exp_calls.size()), 0);

    // Blocking round trip on requester 2
    set_req(2, 1'b1, 1'b1, 8'h15, 64'hA5);
    push_call(2, 1'b1, 8'h15, 64'hA5);
    #1;
    check("blk_ready", 64'(bus.req_ready), 64'h4);
    tick(1);
    bus.req_valid = '0; bus.req_blocking = '0;
    check("blk_ep_valid", 64'(bus.ep_valid), 1);
    check("blk_busy", 64'(bus.busy), 64'h4);
    tick(2);
    send_rsp(2, 64'h1234);
    push_rsp(4'h4, 64'h1234, 1'b0);
    tick(1);
    bus.ep_rsp_valid = 1'b0;
    check("blk_rsp_valid", 64'(bus.rsp_valid), 64'h4);
    check("blk_rsp_data", bus.rsp_data, 64'h1234);
    check("blk_busy_clr", 64'(bus.busy), 0);
    tick(1);
    check("blk_rsp_pulse", 64'(bus.rsp_valid), 0);

    // Backpressure: ptr sits at 3, so requester 3 goes first, then 0 waits behind the stall
    bus.ep_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h20, 64'hB0);
    set_req(3, 1'b1, 1'b0, 8'h23, 64'hB3);
    push_call(3, 1'b0, 8'h23, 64'hB3);
    push_call(0, 1'b0, 8'h20, 64'hB0);
    #1;
    check("bp_first_ready", 64'(bus.req_ready), 64'h8);
    tick(1);
    bus.req_valid[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_ready_low", 64'(bus.req_ready), 0);
      check("bp_hold_id", 64'(bus.ep_id), 64'd3);
      check("bp_hold_data", bus.ep_data, 64'hB3);
      tick(1);
    end
    bus.ep_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.req_ready), 64'h1);
    tick(1);
    bus.req_valid = '0;
    tick(2);
    check("bp_drained", 64'(exp_calls.size()), 0);

    // Unsolicited response to idle requester 1
    send_rsp(1, 64'hDEAD);
    tick(1);
    bus.ep_rsp_valid = 1'b0;
    check("uns_pulse", 64'(bus.unsolicited), 1);
    check("uns_no_rsp", 64'(bus.rsp_valid), 0);
    check("uns_busy", 64'(bus.busy), 0);
    tick(1);
    check("uns_one_cycle", 64'(bus.unsolicited), 0);

    // Blocking accept for 1, then an accept for 0 alongside the response for 1
    set_req(1, 1'b1, 1'b1, 8'h41, 64'hC1);
    push_call(1, 1'b1, 8'h41, 64'hC1);
    tick(1);
    bus.req_valid = '0; bus.req_blocking = '0;
    check("sim_busy1", 64'(bus.busy), 64'h2);
    set_req(0, 1'b1, 1'b0, 8'h40, 64'hC0);
    push_call(0, 1'b0, 8'h40, 64'hC0);
    send_rsp(1, 64'h77);
    push_rsp(4'h2, 64'h77, 1'b0);
    tick(1);
    bus.req_valid = '0; bus.ep_rsp_valid = 1'b0;
    check("sim_busy_clr", 64'(bus.busy), 0);
    check("sim_rsp_valid", 64'(bus.rsp_valid), 64'h2);
    check("sim_no_unsol", 64'(bus.unsolicited), 0);
    tick(2);

`ifdef TBLINK_RPC_ARB_TIMEOUT_EN
    set_req(0, 1'b1, 1'b1, 8'h50, 64'hD0);
    push_call(0, 1'b1, 8'h50, 64'hD0);
    tick(1);
    bus.req_valid = '0; bus.req_blocking = '0;
    tick(15);
    check("to_not_yet", 64'(bus.rsp_valid), 0);
    check("to_still_busy", 64'(bus.busy), 64'h1);
    push_rsp(4'h1, 64'h0, 1'b1);
    tick(1);
    check("to_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("to_rsp_err", 64'(bus.rsp_err), 1);
    check("to_busy_clr", 64'(bus.busy), 0);
    tick(2);
    send_rsp(0, 64'h55);
    tick(1);
    bus.ep_rsp_valid = 1'b0;
    check("to_late_unsol", 64'(bus.unsolicited), 1);
    check("to_late_no_rsp", 64'(bus.rsp_valid), 0);
    tick(1);
`endif

    // Reset while requester 0 is busy and its call is stalled at the endpoint
    bus.ep_ready = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h60, 64'hE0);
    push_call(0, 1'b1, 8'h60, 64'hE0);
    tick(1);
    bus.req_valid = '0; bus.req_blocking = '0;
    check("mid_busy", 64'(bus.busy), 64'h1);
    check("mid_ep_valid", 64'(bus.ep_valid), 1);
    bus.req_valid[2] = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_calls.delete();
    check("mr_ep_valid", 64'(bus.ep_valid), 0);
    check("mr_busy", 64'(bus.busy), 0);
    check("mr_req_ready", 64'(bus.req_ready), 0);
    check("mr_rsp_valid", 64'(bus.rsp_valid), 0);
    check("mr_ep_id", 64'(bus.ep_id), 0);
    check("mr_ep_method", 64'(bus.ep_method), 0);
    check("mr_ep_data", bus.ep_data, 0);
    check("mr_rsp_data", bus.rsp_data, 0);
    bus.req_valid = '0;
    tick(1);
    rst_n = 1'b1;
    bus.ep_ready = 1'b1;
    tick(1);
    send_rsp(0, 64'h99);
    tick(1);
    bus.ep_rsp_valid = 1'b0;
    check("mr_late_unsol", 64'(bus.unsolicited), 1);
    check("mr_late_no_rsp", 64'(bus.rsp_valid), 0);
    check("mr_late_busy", 64'(bus.busy), 0);

    // ptr restarts at 0 after reset: requester 1 beats 3
    set_req(1, 1'b1, 1'b0, 8'h71, 64'hF1);
    set_req(3, 1'b1, 1'b0, 8'h73, 64'hF3);
    push_call(1, 1'b0, 8'h71, 64'hF1);
    push_call(3, 1'b0, 8'h73, 64'hF3);
    #1;
    check("pr_ready1", 64'(bus.req_ready), 64'h2);
    tick(1);
    bus.req_valid[1] = 1'b0;
    #1;
    check("pr_ready3", 64'(bus.req_ready), 64'h8);
    tick(1);
    bus.req_valid = '0;
    tick(3);
    check("end_calls_empty", 64'(exp_calls.size()), 0);
    check("end_rsps_empty", 64'(exp_rsps.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
